// File: rtl/pll_x4_rst_seq.sv
// Reset/lock sequencer around the x4 PLL wrapper. It pulses PLL RST, waits for
// LOCK, debounces it, and only then releases the x4-domain reset. Lock loss in
// RUN and lock timeouts re-cycle the PLL and are counted (saturating).
module pll_x4_rst_seq #(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_lock,
  input  logic             restart,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int MAX_AB = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_N  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int CW     = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [CW-1:0]    RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]    STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            lock_m, lock_s;
  logic            loss_ev, tmo_ev;

  // Two-flop lock synchronizer. It is also held clear while the PLL is in
  // reset so a stale LOCK from before the reset pulse cannot shortcut the
  // debounce; every attempt sees a fresh lock edge.
  always_ff @(posedge clk) begin
    if (!reset_n || pll_rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // Next-state / shared-counter decode; restart overrides every transition.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    loss_ev  = 1'b0;
    tmo_ev   = 1'b0;
    case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end else if (cnt == TMO_LAST) begin
          state_nx = RESET_PLL;
          cnt_nx   = '0;
          tmo_ev   = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      STABLE: begin
        // A dropout here is a debounce glitch, not a loss.
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == STB_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nx = RESET_PLL;
          cnt_nx   = '0;
          loss_ev  = 1'b1;
        end
      end
      default: begin
        state_nx = RESET_PLL;
        cnt_nx   = '0;
      end
    endcase
    // A loss seen in the same cycle as restart is still counted; a timeout
    // is not, since the restart pre-empts that transition.
    if (restart) begin
      state_nx = RESET_PLL;
      cnt_nx   = '0;
      tmo_ev   = 1'b0;
    end
  end

  // State, counter and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pll_rst   <= (state_nx == RESET_PLL);
      sys_rst_n <= (state_nx == RUN);
      ready     <= (state_nx == RUN);
    end
  end

  // Saturating event counters, cleared only by reset_n.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      loss_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      if (loss_ev && loss_cnt != CNT_SAT)
        loss_cnt <= loss_cnt + CNT_W'(1);
      if (tmo_ev && timeout_cnt != CNT_SAT)
        timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pll_x4_rst_seq.sv
// Bench for pll_x4_rst_seq: directed scenarios then random lock/restart/reset
// traffic. A phase-level reference model predicts outputs after every edge;
// a monitor on the falling edge pops and compares them.
module tb_pll_x4_rst_seq;
  localparam int RC   = 4;
  localparam int SC   = 8;
  localparam int TC   = 32;
  localparam int CW   = 2;
  localparam int SATV = (1 << CW) - 1;

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STB  = 2;
  localparam int P_RUN  = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pll_lock = 1'b0;
  logic          restart = 1'b0;
  logic          pll_rst, sys_rst_n, ready;
  logic [CW-1:0] loss_cnt, timeout_cnt;

  always #5 clk = ~clk;

  pll_x4_rst_seq #(
    .RST_CYCLES(RC), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .restart(restart),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready),
    .loss_cnt(loss_cnt), .timeout_cnt(timeout_cnt)
  );

  typedef struct packed {
    logic          pll_rst;
    logic          sys_rst_n;
    logic          ready;
    logic [CW-1:0] loss;
    logic [CW-1:0] tmo;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: phase, edges spent in phase, lock history, event counts.
  int   ph = P_RST;
  int   el = 0;
  int   m_loss = 0;
  int   m_tmo = 0;
  logic h1 = 1'b0;   // lock seen one edge ago
  logic h2 = 1'b0;   // lock seen two edges ago (what the sequencer acts on)

  task automatic model_step(input logic lk, input logic rs, input logic rn);
    logic ls;
    obs_t e;
    ls = h2;
    if (!rn) begin
      ph = P_RST; el = 0; m_loss = 0; m_tmo = 0; h1 = 1'b0; h2 = 1'b0;
    end else begin
      if (ph == P_RST) begin
        h1 = 1'b0; h2 = 1'b0;
      end else begin
        h2 = h1; h1 = lk;
      end
      if (ph == P_RUN && !ls && m_loss < SATV) m_loss++;
      if (rs) begin
        ph = P_RST; el = 0;
      end else begin
        case (ph)
          P_RST: begin
            el++;
            if (el == RC) begin ph = P_WAIT; el = 0; end
          end
          P_WAIT: begin
            if (ls) begin ph = P_STB; el = 0; end
            else begin
              el++;
              if (el == TC) begin
                ph = P_RST; el = 0;
                if (m_tmo < SATV) m_tmo++;
              end
            end
          end
          P_STB: begin
            if (!ls) begin ph = P_WAIT; el = 0; end
            else begin
              el++;
              if (el == SC) begin ph = P_RUN; el = 0; end
            end
          end
          default: begin
            if (!ls) begin ph = P_RST; el = 0; end
          end
        endcase
      end
    end
    e.pll_rst   = (ph == P_RST);
    e.sys_rst_n = (ph == P_RUN);
    e.ready     = (ph == P_RUN);
    e.loss      = CW'(m_loss);
    e.tmo       = CW'(m_tmo);
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs with the queued prediction for the last edge.
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {pll_rst, sys_rst_n, ready, loss_cnt, timeout_cnt};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs @%0t: got rst=%b srn=%b rdy=%b loss=%0d tmo=%0d, expected rst=%b srn=%b rdy=%b loss=%0d tmo=%0d",
                 $time, a.pll_rst, a.sys_rst_n, a.ready, a.loss, a.tmo,
                 e.pll_rst, e.sys_rst_n, e.ready, e.loss, e.tmo);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // One clock: drive inputs on the falling edge, predict after the rising edge.
  task automatic cyc(input logic lk, input logic rs, input logic rn);
    @(negedge clk);
    pll_lock = lk; restart = rs; reset_n = rn;
    @(posedge clk);
    #1;
    model_step(lk, rs, rn);
  endtask

  task automatic do_reset(input logic lk);
    repeat (3) cyc(lk, 1'b0, 1'b0);
  endtask

  task automatic reach_run(input string nm);
    for (int i = 0; i < 200 && ph != P_RUN; i++) cyc(1'b1, 1'b0, 1'b1);
    chk(nm, int'(ready), 1);
  endtask

  task automatic reach_stable();
    for (int i = 0; i < 200 && ph != P_STB; i++) cyc(1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    // Power-up with lock tied high.
    do_reset(1'b1);
    chk("reset_pll_rst", int'(pll_rst), 1);
    chk("reset_sys_rst_n", int'(sys_rst_n), 0);
    chk("reset_ready", int'(ready), 0);
    chk("reset_cnts", int'({loss_cnt, timeout_cnt}), 0);
    for (int n = 1; n <= 20; n++) begin
      cyc(1'b1, 1'b0, 1'b1);
      if (n == 3)  chk("pwr_pll_rst_e3", int'(pll_rst), 1);
      if (n == 4)  chk("pwr_pll_rst_e4", int'(pll_rst), 0);
      if (n == 14) chk("pwr_ready_e14", int'(ready), 0);
      if (n == 15) chk("pwr_ready_e15", int'(ready), 1);
      if (n == 15) chk("pwr_sys_rst_n_e15", int'(sys_rst_n), 1);
      if (n == 20) chk("pwr_cnts", int'({loss_cnt, timeout_cnt}), 0);
    end

    // Lock never asserts: 36-cycle retry period, timeout count saturates.
    do_reset(1'b0);
    for (int n = 1; n <= 160; n++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (n == 35) chk("nolock_rst_lo_e35", int'(pll_rst), 0);
      if (n == 36) chk("nolock_rst_hi_e36", int'(pll_rst), 1);
      if (n == 39) chk("nolock_rst_hi_e39", int'(pll_rst), 1);
      if (n == 40) chk("nolock_rst_lo_e40", int'(pll_rst), 0);
      if (n % 36 == 0) chk("nolock_tmo", int'(timeout_cnt), (n / 36 > 3) ? 3 : n / 36);
      if (n == 160) chk("nolock_sys_rst_n", int'(sys_rst_n), 0);
    end

    // Lock glitch in STABLE restarts the debounce without counting a loss.
    do_reset(1'b1);
    for (int i = 0; i < 200 && !(ph == P_STB && el == 5); i++) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    reach_run("glitch_reach_run");
    chk("glitch_loss_cnt", int'(loss_cnt), 0);

    // Lock loss in RUN.
    cyc(1'b0, 1'b0, 1'b1);                       // Ex
    chk("loss_ready_ex", int'(ready), 1);
    cyc(1'b0, 1'b0, 1'b1);                       // Ex+1
    chk("loss_pll_rst_ex1", int'(pll_rst), 0);
    cyc(1'b0, 1'b0, 1'b1);                       // Ex+2
    chk("loss_pll_rst_ex2", int'(pll_rst), 1);
    chk("loss_sys_rst_n_ex2", int'(sys_rst_n), 0);
    chk("loss_cnt_1", int'(loss_cnt), 1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);                       // Ex+5
    chk("loss_pll_rst_ex5", int'(pll_rst), 1);
    cyc(1'b0, 1'b0, 1'b1);                       // Ex+6
    chk("loss_pll_rst_ex6", int'(pll_rst), 0);
    reach_run("loss_reach_run");
    chk("loss_sys_rst_n_back", int'(sys_rst_n), 1);

    // Restart in RUN: immediate, no synchronizer delay, no loss counted.
    cyc(1'b1, 1'b1, 1'b1);
    chk("restart_pll_rst", int'(pll_rst), 1);
    chk("restart_sys_rst_n", int'(sys_rst_n), 0);
    chk("restart_loss_cnt", int'(loss_cnt), 1);
    reach_run("restart_reach_run");

    // Restart coincident with a loss still counts the loss.
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("restart_loss_same", int'(loss_cnt), 2);
    chk("restart_loss_rst", int'(pll_rst), 1);

    // reset_n pulse while in STABLE.
    reach_stable();
    cyc(1'b1, 1'b0, 1'b0);
    chk("midrst_pll_rst", int'(pll_rst), 1);
    chk("midrst_ready", int'(ready), 0);
    chk("midrst_cnts", int'({loss_cnt, timeout_cnt}), 0);
    reach_run("midrst_reach_run");

    // Random traffic: lock held for random stretches, rare restart/reset.
    for (int seg = 0; seg < 150; seg++) begin
      logic lk;
      int   len;
      lk  = ($urandom_range(0, 3) != 0);
      len = lk ? $urandom_range(1, 60) : $urandom_range(1, 45);
      for (int k = 0; k < len; k++)
        cyc(lk, ($urandom_range(0, 79) == 0), ($urandom_range(0, 299) != 0));
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
